// File: rtl/datapath_mc_pkg.sv
// Shared definitions for the multicycle datapath: ALU opcodes, FSM states
// and the addresses of the two hard-wired constant registers.
package datapath_mc_pkg;

  localparam int unsigned ALU_AND   = 0;
  localparam int unsigned ALU_OR    = 1;
  localparam int unsigned ALU_XOR   = 2;
  localparam int unsigned ALU_ADD   = 3;
  localparam int unsigned ALU_SUB   = 4;
  localparam int unsigned ALU_ADDC  = 5;
  localparam int unsigned ALU_SLL   = 6;
  localparam int unsigned ALU_SRL   = 7;
  localparam int unsigned ALU_SRA   = 8;
  localparam int unsigned ALU_PASSA = 9;
  localparam int unsigned ALU_PASSB = 10;
  localparam int unsigned ALU_NOTA  = 11;

  localparam int unsigned REG_ZERO_ADDR = 0;
  localparam int unsigned REG_ONE_ADDR  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MEMWAIT = 2'd2
  } dp_state_e;

endpackage

// File: rtl/datapath_mc_alu.sv
// Combinational ALU: logic, add/sub with carry, shifts and pass ops,
// producing N/Z/V/C alongside the result.
module datapath_mc_alu
  import datapath_mc_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic [DATAWIDTH_BUS-1:0]           a_i,
  input  logic [DATAWIDTH_BUS-1:0]           b_i,
  input  logic                               carry_i,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] op_i,
  output logic [DATAWIDTH_BUS-1:0]           result_o,
  output logic                               n_o,
  output logic                               z_o,
  output logic                               v_o,
  output logic                               c_o
);

  localparam int W   = DATAWIDTH_BUS;
  localparam int SHW = $clog2(DATAWIDTH_BUS);

  logic [31:0]         op_w;
  logic [W:0]          sum;
  logic [SHW-1:0]      shamt;
  logic signed [W-1:0] a_s;

  always_comb begin
    op_w     = 32'(op_i);
    shamt    = b_i[SHW-1:0];
    a_s      = a_i;
    sum      = '0;
    result_o = '0;
    v_o      = 1'b0;
    c_o      = 1'b0;
    case (op_w)
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_ADD, ALU_ADDC: begin
        sum      = {1'b0, a_i} + {1'b0, b_i}
                 + {{W{1'b0}}, (op_w == ALU_ADDC) && carry_i};
        result_o = sum[W-1:0];
        c_o      = sum[W];
        v_o      = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      ALU_SUB: begin
        result_o = a_i - b_i;
        c_o      = a_i < b_i;
        v_o      = (a_i[W-1] != b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
      end
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = a_s >>> shamt;
      ALU_PASSA: result_o = a_i;
      ALU_PASSB: result_o = b_i;
      ALU_NOTA:  result_o = ~a_i;
      default:   result_o = '0;
    endcase
    n_o = result_o[W-1];
    z_o = (result_o == '0);
  end

endmodule

// File: rtl/datapath_multicycle.sv
// Multicycle datapath: register file with constant 0/1 registers, operand
// latch, ALU or memory write-back, and the N/Z/V/C status register.
module datapath_multicycle
  import datapath_mc_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int NUM_REGS                = 16,
  parameter int DATAWIDTH_MIR_DIRECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic                               DATAPATH_MC_CLOCK_50,
  input  logic                               DATAPATH_MC_RESET_InLow,
  input  logic                               DATAPATH_MC_UopValid_In,
  output logic                               DATAPATH_MC_UopReady_Out,
  input  logic [DATAWIDTH_MIR_DIRECTION-1:0] DATAPATH_MC_DirA_InBus,
  input  logic [DATAWIDTH_MIR_DIRECTION-1:0] DATAPATH_MC_DirB_InBus,
  input  logic [DATAWIDTH_MIR_DIRECTION-1:0] DATAPATH_MC_DirC_InBus,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] DATAPATH_MC_ALUOperation_InBus,
  input  logic                               DATAPATH_MC_SelectC_In,
  input  logic                               DATAPATH_MC_WriteEn_In,
  input  logic                               DATAPATH_MC_FlagWrite_In,
  input  logic [DATAWIDTH_BUS-1:0]           DATAPATH_MC_MemoryData_InBus,
  input  logic                               DATAPATH_MC_MemValid_In,
  output logic                               DATAPATH_MC_MemRequest_Out,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_MC_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_MC_B_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           DATAPATH_MC_Result_OutBus,
  output logic                               DATAPATH_MC_FlagNegative_Out,
  output logic                               DATAPATH_MC_FlagZero_Out,
  output logic                               DATAPATH_MC_FlagOverflow_Out,
  output logic                               DATAPATH_MC_FlagCarry_Out
);

  localparam int W     = DATAWIDTH_BUS;
  localparam int DIR_W = DATAWIDTH_MIR_DIRECTION;
  localparam int IDX_W = $clog2(NUM_REGS);

  dp_state_e                          state_q;
  logic                               ready_q, memreq_q;
  logic [W-1:0]                       regs_q [2:NUM_REGS-1];
  logic [W-1:0]                       opa_q, opb_q, result_q;
  logic [DIR_W-1:0]                   dirc_q;
  logic [DATAWIDTH_ALU_SELECTION-1:0] op_q;
  logic                               selc_q, wen_q, fwen_q;
  logic                               n_q, z_q, v_q, c_q;

  logic [W-1:0] alu_res_d;
  logic         alu_n, alu_z, alu_v, alu_c;
  logic         wr_ok;

  function automatic logic in_range(input logic [DIR_W-1:0] addr);
    return {1'b0, addr} < (DIR_W+1)'(NUM_REGS);
  endfunction

  // Constants and out-of-range addresses never touch storage.
  function automatic logic [W-1:0] reg_read(input logic [DIR_W-1:0] addr);
    if (addr == DIR_W'(REG_ZERO_ADDR) || !in_range(addr)) return '0;
    if (addr == DIR_W'(REG_ONE_ADDR)) return W'(1);
    return regs_q[addr[IDX_W-1:0]];
  endfunction

  assign wr_ok = wen_q && in_range(dirc_q) && (dirc_q != DIR_W'(REG_ZERO_ADDR))
               && (dirc_q != DIR_W'(REG_ONE_ADDR));

  datapath_mc_alu #(
    .DATAWIDTH_BUS           (DATAWIDTH_BUS),
    .DATAWIDTH_ALU_SELECTION (DATAWIDTH_ALU_SELECTION)
  ) u_alu (
    .a_i      (opa_q),
    .b_i      (opb_q),
    .carry_i  (c_q),
    .op_i     (op_q),
    .result_o (alu_res_d),
    .n_o      (alu_n),
    .z_o      (alu_z),
    .v_o      (alu_v),
    .c_o      (alu_c)
  );

  always_ff @(posedge DATAPATH_MC_CLOCK_50) begin
    if (!DATAPATH_MC_RESET_InLow) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      memreq_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      dirc_q   <= '0;
      op_q     <= '0;
      selc_q   <= 1'b0;
      wen_q    <= 1'b0;
      fwen_q   <= 1'b0;
      {n_q, z_q, v_q, c_q} <= 4'b0000;
      for (int i = 2; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (DATAPATH_MC_UopValid_In) begin
            opa_q   <= reg_read(DATAPATH_MC_DirA_InBus);
            opb_q   <= reg_read(DATAPATH_MC_DirB_InBus);
            dirc_q  <= DATAPATH_MC_DirC_InBus;
            op_q    <= DATAPATH_MC_ALUOperation_InBus;
            selc_q  <= DATAPATH_MC_SelectC_In;
            wen_q   <= DATAPATH_MC_WriteEn_In;
            fwen_q  <= DATAPATH_MC_FlagWrite_In;
            ready_q <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (!selc_q) begin
            if (wr_ok) regs_q[dirc_q[IDX_W-1:0]] <= alu_res_d;
            result_q <= alu_res_d;
            if (fwen_q) {n_q, z_q, v_q, c_q} <= {alu_n, alu_z, alu_v, alu_c};
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            memreq_q <= 1'b1;
            state_q  <= MEMWAIT;
          end
        end
        MEMWAIT: begin
          if (DATAPATH_MC_MemValid_In) begin
            if (wr_ok) regs_q[dirc_q[IDX_W-1:0]] <= DATAPATH_MC_MemoryData_InBus;
            result_q <= DATAPATH_MC_MemoryData_InBus;
            memreq_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          memreq_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign DATAPATH_MC_UopReady_Out     = ready_q;
  assign DATAPATH_MC_MemRequest_Out   = memreq_q;
  assign DATAPATH_MC_A_OutBus         = opa_q;
  assign DATAPATH_MC_B_OutBus         = opb_q;
  assign DATAPATH_MC_Result_OutBus    = result_q;
  assign DATAPATH_MC_FlagNegative_Out = n_q;
  assign DATAPATH_MC_FlagZero_Out     = z_q;
  assign DATAPATH_MC_FlagOverflow_Out = v_q;
  assign DATAPATH_MC_FlagCarry_Out    = c_q;

endmodule

// File: tb/tb_datapath_multicycle.sv
// Directed bench for datapath_multicycle: ALU ops, flags, constant
// registers, loads with wait states and reset during a load.
module tb_datapath_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uop_valid = 1'b0;
  logic        uop_ready;
  logic [5:0]  dir_a = '0, dir_b = '0, dir_c = '0;
  logic [3:0]  alu_op = '0;
  logic        sel_c = 1'b0, wen = 1'b0, fwen = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_req;
  logic [31:0] a_out, b_out, result;
  logic        fn, fz, fv, fc;

  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  datapath_multicycle dut (
    .DATAPATH_MC_CLOCK_50           (clk),
    .DATAPATH_MC_RESET_InLow        (rst_n),
    .DATAPATH_MC_UopValid_In        (uop_valid),
    .DATAPATH_MC_UopReady_Out       (uop_ready),
    .DATAPATH_MC_DirA_InBus         (dir_a),
    .DATAPATH_MC_DirB_InBus         (dir_b),
    .DATAPATH_MC_DirC_InBus         (dir_c),
    .DATAPATH_MC_ALUOperation_InBus (alu_op),
    .DATAPATH_MC_SelectC_In         (sel_c),
    .DATAPATH_MC_WriteEn_In         (wen),
    .DATAPATH_MC_FlagWrite_In       (fwen),
    .DATAPATH_MC_MemoryData_InBus   (mem_data),
    .DATAPATH_MC_MemValid_In        (mem_valid),
    .DATAPATH_MC_MemRequest_Out     (mem_req),
    .DATAPATH_MC_A_OutBus           (a_out),
    .DATAPATH_MC_B_OutBus           (b_out),
    .DATAPATH_MC_Result_OutBus      (result),
    .DATAPATH_MC_FlagNegative_Out   (fn),
    .DATAPATH_MC_FlagZero_Out       (fz),
    .DATAPATH_MC_FlagOverflow_Out   (fv),
    .DATAPATH_MC_FlagCarry_Out      (fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nzvc();
    return {28'd0, fn, fz, fv, fc};
  endfunction

  // Returns one ns after the accepting edge.
  task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                       input logic [3:0] op, input logic sc, input logic we, input logic fw);
    int n = 0;
    @(negedge clk);
    while (!uop_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!uop_ready) check("ready_timeout", {31'd0, uop_ready}, 32'd1);
    dir_a = a; dir_b = b; dir_c = c; alu_op = op;
    sel_c = sc; wen = we; fwen = fw; uop_valid = 1'b1;
    @(posedge clk);
    #1 uop_valid = 1'b0;
  endtask

  task automatic alu(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                     input logic [3:0] op, input logic we, input logic fw);
    issue(a, b, c, op, 1'b0, we, fw);
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [5:0] addr, output logic [31:0] val);
    alu(addr, 6'd0, 6'd0, 4'd9, 1'b0, 1'b0);
    val = result;
  endtask

  // Load with nwait idle MemValid cycles; reports cycles MemRequest was seen high.
  task automatic load(input logic [5:0] c, input logic [31:0] data, input int nwait,
                      output int req_cycles);
    req_cycles = 0;
    issue(6'd0, 6'd0, c, 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    if (mem_req) req_cycles++;
    @(posedge clk);
    for (int i = 0; i <= nwait; i++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      mem_valid = (i == nwait);
      mem_data  = data;
      @(posedge clk);
      #1 mem_valid = 1'b0;
    end
  endtask

  logic [31:0] v;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", {31'd0, uop_ready}, 32'd1);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", nzvc(), 32'd0);
    check("rst_opa", a_out, 32'd0);

    // r2 = r1 + r1, with latency and ready checks
    issue(6'd1, 6'd1, 6'd2, 4'd3, 1'b0, 1'b1, 1'b1);
    check("add_ready_low", {31'd0, uop_ready}, 32'd0);
    check("add_opa", a_out, 32'd1);
    check("add_opb", b_out, 32'd1);
    @(posedge clk);
    #1;
    check("add_result", result, 32'd2);
    check("add_flags", nzvc(), 32'b0000);
    check("add_ready_back", {31'd0, uop_ready}, 32'd1);
    read_reg(6'd2, v);
    check("r2_eq_2", v, 32'd2);

    // Signed overflow on ADD, zero on SUB
    load(6'd2, 32'h7FFF_FFFF, 0, cnt);
    alu(6'd1, 6'd0, 6'd3, 4'd3, 1'b1, 1'b0);
    alu(6'd2, 6'd3, 6'd4, 4'd3, 1'b1, 1'b1);
    check("ovf_result", result, 32'h8000_0000);
    check("ovf_flags", nzvc(), 32'b1010);
    read_reg(6'd4, v);
    check("r4", v, 32'h8000_0000);
    alu(6'd3, 6'd3, 6'd6, 4'd4, 1'b1, 1'b1);
    check("sub_result", result, 32'd0);
    check("sub_flags", nzvc(), 32'b0100);

    // Writes to constant and out-of-range addresses are dropped
    alu(6'd1, 6'd1, 6'd0, 4'd3, 1'b1, 1'b1);
    check("w0_flags", nzvc(), 32'b0000);
    read_reg(6'd0, v);
    check("r0_still_0", v, 32'd0);
    alu(6'd0, 6'd0, 6'd16, 4'd11, 1'b1, 1'b1);
    check("nota_result", result, 32'hFFFF_FFFF);
    check("w16_flags", nzvc(), 32'b1000);
    read_reg(6'd16, v);
    check("r16_reads_0", v, 32'd0);
    read_reg(6'd1, v);
    check("r1_still_1", v, 32'd1);

    // Load with five wait states
    load(6'd5, 32'hDEAD_BEEF, 5, cnt);
    check("ld_req_cycles", cnt, 32'd6);
    check("ld_req_low", {31'd0, mem_req}, 32'd0);
    check("ld_result", result, 32'hDEAD_BEEF);
    check("ld_flags_kept", nzvc(), 32'b1000);
    read_reg(6'd5, v);
    check("r5", v, 32'hDEAD_BEEF);

    // Shifts, carry out and ADDC
    load(6'd7, 32'h8000_0000, 0, cnt);
    load(6'd8, 32'd31, 0, cnt);
    load(6'd10, 32'd32, 0, cnt);
    alu(6'd7, 6'd8, 6'd9, 4'd8, 1'b1, 1'b1);
    check("sra_result", result, 32'hFFFF_FFFF);
    check("sra_flags", nzvc(), 32'b1000);
    alu(6'd1, 6'd10, 6'd11, 4'd6, 1'b1, 1'b0);
    check("sll32_result", result, 32'd1);
    alu(6'd9, 6'd1, 6'd12, 4'd3, 1'b1, 1'b1);
    check("carry_result", result, 32'd0);
    check("carry_flags", nzvc(), 32'b0101);
    alu(6'd1, 6'd1, 6'd12, 4'd5, 1'b1, 1'b1);
    check("addc_result", result, 32'd3);
    check("addc_flags", nzvc(), 32'b0000);

    // Reset during MEMWAIT abandons the load
    issue(6'd0, 6'd0, 6'd13, 4'd0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("mw_req_high", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_data  = 32'h1234_5678;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    check("mr_ready", {31'd0, uop_ready}, 32'd1);
    check("mr_memreq", {31'd0, mem_req}, 32'd0);
    check("mr_result", result, 32'd0);
    check("mr_flags", nzvc(), 32'd0);
    read_reg(6'd13, v);
    check("mr_r13", v, 32'd0);
    read_reg(6'd5, v);
    check("mr_r5_cleared", v, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
